// File: rtl/cga_vram_arbiter_if.sv
// Bus bundle between the CGA VRAM arbiter, its CPU/pixel requesters and the VRAM.
// slave = arbiter side, master = requesters plus memory side.
interface cga_vram_arbiter_if #(
  parameter int AW = 14
);
  logic          cpu_req;
  logic          cpu_we;
  logic [18:0]   cpu_addr;
  logic [7:0]    cpu_din;
  logic [7:0]    cpu_dout;
  logic          cpu_ack;
  logic          cpu_busy;
  logic          pix_req;
  logic [18:0]   pix_addr;
  logic          pix_gnt;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_din, pix_req, pix_addr, mem_dout,
    output cpu_dout, cpu_ack, cpu_busy, pix_gnt, pix_valid, pix_data,
           mem_addr, mem_we, mem_din
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_din, pix_req, pix_addr, mem_dout,
    input  cpu_dout, cpu_ack, cpu_busy, pix_gnt, pix_valid, pix_data,
           mem_addr, mem_we, mem_din
  );
endinterface

// File: rtl/cga_vram_arbiter.sv
// Single-port VRAM arbiter: pixel fetch has priority, a pending CPU access is
// forced through after MAX_WAIT consecutive pixel wins.
module cga_vram_arbiter #(
  parameter int MAX_WAIT = 7,
  parameter int AW       = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  cga_vram_arbiter_if.slave bus
);
  localparam int            WW   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RDWAIT, S_ACK} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_buf_we;
  logic [AW-1:0] r_buf_addr;
  logic [7:0]    r_buf_din;
  logic [WW-1:0] r_wait_cnt;
  logic          r_pix_vld_p1;
  logic          r_cpu_rd_p1;
  logic          r_pix_vld_p2;
  logic [7:0]    r_pix_data_p2;
  logic [7:0]    r_cpu_dout_p2;
  logic          w_pix_issue;
  logic          w_cpu_issue;
  logic          w_unused;

  assign w_unused = &{1'b0, bus.cpu_addr[18:AW], bus.pix_addr[18:AW]};

  always_comb begin
    w_pix_issue = bus.pix_req && (r_wait_cnt < WMAX);
    w_cpu_issue = !w_pix_issue && (r_state == S_PEND);
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.cpu_req) w_state_nxt = S_PEND;
      S_PEND:   if (w_cpu_issue) w_state_nxt = r_buf_we ? S_ACK : S_RDWAIT;
      S_RDWAIT: w_state_nxt = S_ACK;
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Issue stage: one VRAM access per cycle, address bus idles at zero.
  assign bus.pix_gnt  = w_pix_issue;
  assign bus.mem_addr = w_pix_issue ? bus.pix_addr[AW-1:0] :
                        w_cpu_issue ? r_buf_addr : '0;
  assign bus.mem_we   = w_cpu_issue && r_buf_we;
  assign bus.mem_din  = (w_cpu_issue && r_buf_we) ? r_buf_din : '0;
  assign bus.cpu_busy = (r_state == S_PEND) || (r_state == S_RDWAIT);
  assign bus.cpu_ack  = (r_state == S_ACK);
  assign bus.cpu_dout = r_cpu_dout_p2;
  assign bus.pix_valid = r_pix_vld_p2;
  assign bus.pix_data  = r_pix_data_p2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wait_cnt    <= '0;
      r_pix_vld_p1  <= 1'b0;
      r_cpu_rd_p1   <= 1'b0;
      r_pix_vld_p2  <= 1'b0;
      r_pix_data_p2 <= '0;
      r_cpu_dout_p2 <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cpu_issue)
        r_wait_cnt <= '0;
      else if ((r_state == S_PEND) && w_pix_issue)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      // Stage p1: owner tag of the access issued last cycle; mem_dout now holds its data.
      r_pix_vld_p1 <= w_pix_issue;
      r_cpu_rd_p1  <= w_cpu_issue && !r_buf_we;
      // Stage p2: returned data steered to its owner.
      r_pix_vld_p2 <= r_pix_vld_p1;
      if (r_pix_vld_p1) r_pix_data_p2 <= bus.mem_dout;
      if (r_cpu_rd_p1)  r_cpu_dout_p2 <= bus.mem_dout;
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && bus.cpu_req) begin
      r_buf_we   <= bus.cpu_we;
      r_buf_addr <= bus.cpu_addr[AW-1:0];
      r_buf_din  <= bus.cpu_din;
    end
  end
endmodule
